// File: rtl/matrix_input_mode_pkg.sv
// Shared constants for the matrix input path: error codes, ASCII delimiters,
// FSM state encodings reported on sub_state, and a byte classifier.
package matrix_input_mode_pkg;

  localparam int ELEMENT_WIDTH_DEF   = 8;
  localparam int BRAM_ADDR_WIDTH_DEF = 10;
  localparam int MAX_MATRIX_DIM      = 5;
  localparam int ALLOC_TIMEOUT_DEF   = 16;

  // Error codes presented on error_code
  localparam logic [3:0] ERR_NONE        = 4'd0;
  localparam logic [3:0] ERR_BAD_CHAR    = 4'd1;
  localparam logic [3:0] ERR_DIM_RANGE   = 4'd2;
  localparam logic [3:0] ERR_VALUE_RANGE = 4'd3;
  localparam logic [3:0] ERR_NO_SPACE    = 4'd4;

  // ASCII bytes the tokeniser recognises
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  // FSM state encodings, also the values seen on sub_state
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_GET_M    = 4'd1;
  localparam logic [3:0] ST_GET_N    = 4'd2;
  localparam logic [3:0] ST_ALLOC    = 4'd3;
  localparam logic [3:0] ST_GET_ELEM = 4'd4;
  localparam logic [3:0] ST_DONE     = 4'd5;
  localparam logic [3:0] ST_ERROR    = 4'd6;

  typedef enum logic [1:0] {
    BYTE_DIGIT = 2'd0,
    BYTE_DELIM = 2'd1,
    BYTE_OTHER = 2'd2
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e c;
    c = BYTE_OTHER;
    if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
      c = BYTE_DIGIT;
    end else if (b == ASCII_SPACE || b == ASCII_CR ||
                 b == ASCII_LF || b == ASCII_COMMA) begin
      c = BYTE_DELIM;
    end
    return c;
  endfunction

endpackage

// File: rtl/matrix_input_mode_ascii_dec_token.sv
// ASCII decimal tokeniser: accumulates digits into a value, flags overflow
// beyond the element range, and reports a completed token on a delimiter
// that follows at least one digit. Delimiters with nothing pending are
// ignored; any other byte is reported as a bad character.
module matrix_input_mode_ascii_dec_token
  import matrix_input_mode_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [7:0]               i_byte,
  output logic                     o_digit,
  output logic                     o_token_done,
  output logic                     o_bad_char,
  output logic                     o_ovf,
  output logic [ELEMENT_WIDTH+3:0] o_value
);

  localparam int AW = ELEMENT_WIDTH + 4;
  localparam logic [AW+3:0] MAX_VAL = (AW+4)'((64'd1 << ELEMENT_WIDTH) - 64'd1);

  logic [AW-1:0] r_acc;
  logic          r_ovf;
  logic          r_pending;
  byte_class_e   w_class;
  logic [AW+3:0] w_next;

  assign w_class = classify_byte(i_byte);
  // acc*10 + digit, computed four bits wider so the overflow test is exact
  assign w_next  = ({4'd0, r_acc} << 3) + ({4'd0, r_acc} << 1)
                 + {{AW{1'b0}}, i_byte[3:0]};

  assign o_digit      = i_valid && (w_class == BYTE_DIGIT);
  assign o_token_done = i_valid && (w_class == BYTE_DELIM) && r_pending;
  assign o_bad_char   = i_valid && (w_class == BYTE_OTHER);
  assign o_value      = r_acc;
  assign o_ovf        = r_ovf;

  // Accumulator: grows on digits, restarts after a token or a bad byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_pending <= 1'b0;
    end else if (i_clear) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_pending <= 1'b0;
    end else if (o_digit) begin
      r_acc     <= w_next[AW-1:0];
      r_ovf     <= r_ovf | (w_next > MAX_VAL);
      r_pending <= 1'b1;
    end else if (o_token_done || o_bad_char) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_input_mode.sv
// matrix_input_mode: parses "m n e0 e1 ..." ASCII decimal from the UART,
// validates dimensions, requests a slot from the matrix manager and writes
// the elements row-major into BRAM, pulsing commit when the matrix is full.
// Optional feature: define INPUT_ECHO_EN to echo consumed bytes on tx.
//
// Handshakes: rx_valid is a one-cycle strobe, the byte is consumed the same
// cycle unless the FSM is in ALLOC or ERROR (dropped). alloc_req is a level
// held until alloc_ok / alloc_fail (single-cycle strobes) or the timeout.
// mem_wr_en, commit, clear_rx_buffer and tx_start are one-cycle pulses with
// no back-pressure.
module matrix_input_mode
  import matrix_input_mode_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH_DEF,
  parameter int MAX_DIM       = MAX_MATRIX_DIM,
  parameter int ALLOC_TIMEOUT = ALLOC_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     clear_rx_buffer,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     alloc_req,
  output logic [3:0]               alloc_m,
  output logic [3:0]               alloc_n,
  input  logic                     alloc_ok,
  input  logic                     alloc_fail,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic                     commit,
  output logic [3:0]               error_code,
  output logic [3:0]               sub_state
);

  localparam int VW = ELEMENT_WIDTH + 4;
  localparam int TW = $clog2(ALLOC_TIMEOUT + 1);
  localparam logic [VW-1:0] MAX_DIM_V = VW'(MAX_DIM);

  logic [3:0]               r_state;
  logic [3:0]               w_next_state;
  logic [3:0]               r_err;
  logic [3:0]               r_m;
  logic [3:0]               r_n;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [7:0]               r_idx;
  logic [TW-1:0]            r_timer;
  logic                     r_wr_en;
  logic [ADDR_WIDTH-1:0]    r_wr_addr;
  logic [ELEMENT_WIDTH-1:0] r_wr_data;

  logic                     w_consume;
  logic                     w_tok_clear;
  logic                     w_tok_digit;
  logic                     w_tok_done;
  logic                     w_tok_bad;
  logic                     w_tok_ovf;
  logic [VW-1:0]            w_tok_value;
  logic                     w_dim_ok;
  logic [7:0]               w_total;
  logic                     w_last_elem;
  logic                     w_timeout;
  logic                     w_first_digit;
  logic                     w_set_err;
  logic [3:0]               w_err_code;

  // A byte is consumed only in states that parse; ALLOC and ERROR drop it
  assign w_consume = rx_valid && mode_active &&
                     (r_state == ST_IDLE || r_state == ST_GET_M ||
                      r_state == ST_GET_N || r_state == ST_GET_ELEM ||
                      r_state == ST_DONE);
  assign w_tok_clear = !mode_active || (r_state == ST_ERROR);

  matrix_input_mode_ascii_dec_token #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH)
  ) u_token (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_tok_clear),
    .i_valid      (w_consume),
    .i_byte       (rx_data),
    .o_digit      (w_tok_digit),
    .o_token_done (w_tok_done),
    .o_bad_char   (w_tok_bad),
    .o_ovf        (w_tok_ovf),
    .o_value      (w_tok_value)
  );

  assign w_dim_ok      = !w_tok_ovf && (w_tok_value != '0) && (w_tok_value <= MAX_DIM_V);
  assign w_total       = {4'd0, r_m} * {4'd0, r_n};
  assign w_last_elem   = (r_idx == w_total - 8'd1);
  assign w_timeout     = (r_timer == TW'(ALLOC_TIMEOUT - 1));
  assign w_first_digit = w_tok_digit && (r_state == ST_IDLE || r_state == ST_DONE);

  // Next-state and error-code selection
  always_comb begin
    w_next_state = r_state;
    w_set_err    = 1'b0;
    w_err_code   = ERR_NONE;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE behaves like IDLE so a byte arriving with the last write starts the next matrix
        if (w_tok_digit) begin
          w_next_state = ST_GET_M;
        end else if (w_tok_bad) begin
          w_next_state = ST_ERROR;
          w_set_err    = 1'b1;
          w_err_code   = ERR_BAD_CHAR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GET_M, ST_GET_N: begin
        if (w_tok_bad) begin
          w_next_state = ST_ERROR;
          w_set_err    = 1'b1;
          w_err_code   = ERR_BAD_CHAR;
        end else if (w_tok_done) begin
          if (w_dim_ok) begin
            w_next_state = (r_state == ST_GET_M) ? ST_GET_N : ST_ALLOC;
          end else begin
            w_next_state = ST_ERROR;
            w_set_err    = 1'b1;
            w_err_code   = ERR_DIM_RANGE;
          end
        end
      end
      ST_ALLOC: begin
        if (alloc_ok) begin
          w_next_state = ST_GET_ELEM;
        end else if (alloc_fail || w_timeout) begin
          w_next_state = ST_ERROR;
          w_set_err    = 1'b1;
          w_err_code   = ERR_NO_SPACE;
        end
      end
      ST_GET_ELEM: begin
        if (w_tok_bad) begin
          w_next_state = ST_ERROR;
          w_set_err    = 1'b1;
          w_err_code   = ERR_BAD_CHAR;
        end else if (w_tok_done) begin
          if (w_tok_ovf) begin
            w_next_state = ST_ERROR;
            w_set_err    = 1'b1;
            w_err_code   = ERR_VALUE_RANGE;
          end else if (w_last_elem) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_ERROR: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
    if (!mode_active) begin
      w_next_state = ST_IDLE;
      w_set_err    = 1'b0;
    end
  end

  // State, latched dimensions/base, element index and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_err     <= ERR_NONE;
      r_m       <= 4'd0;
      r_n       <= 4'd0;
      r_base    <= '0;
      r_idx     <= 8'd0;
      r_timer   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= 1'b0;
      if (w_set_err) begin
        r_err <= w_err_code;
      end else if (w_first_digit) begin
        r_err <= ERR_NONE;
      end
      if (!mode_active) begin
        r_idx   <= 8'd0;
        r_timer <= '0;
      end else begin
        case (r_state)
          ST_GET_M: begin
            if (w_tok_done && w_dim_ok) r_m <= w_tok_value[3:0];
          end
          ST_GET_N: begin
            r_timer <= '0;
            if (w_tok_done && w_dim_ok) r_n <= w_tok_value[3:0];
          end
          ST_ALLOC: begin
            r_timer <= r_timer + 1'b1;
            if (alloc_ok) begin
              r_base <= alloc_addr;
              r_idx  <= 8'd0;
            end
          end
          ST_GET_ELEM: begin
            if (w_tok_done && !w_tok_ovf && !w_tok_bad) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_base + ADDR_WIDTH'(r_idx);
              r_wr_data <= w_tok_value[ELEMENT_WIDTH-1:0];
              r_idx     <= r_idx + 8'd1;
            end
          end
          ST_ERROR: r_idx <= 8'd0;
          default: ;
        endcase
      end
    end
  end

  assign sub_state       = r_state;
  assign error_code      = r_err;
  assign alloc_req       = (r_state == ST_ALLOC);
  assign alloc_m         = r_m;
  assign alloc_n         = r_n;
  assign mem_wr_en       = r_wr_en;
  assign mem_wr_addr     = r_wr_addr;
  assign mem_wr_data     = r_wr_data;
  assign commit          = (r_state == ST_DONE);
  assign clear_rx_buffer = (r_state == ST_ERROR);

`ifdef INPUT_ECHO_EN
  logic [7:0] r_echo_buf;
  logic       r_echo_full;
  logic       r_tx_start;
  logic [7:0] r_tx_data;

  // One-byte echo buffer: newest consumed byte wins, drained when the UART is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_buf  <= 8'd0;
      r_echo_full <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'd0;
    end else begin
      r_tx_start <= 1'b0;
      if (r_echo_full && !tx_busy && !r_tx_start) begin
        r_tx_start  <= 1'b1;
        r_tx_data   <= r_echo_buf;
        r_echo_full <= 1'b0;
      end
      if (w_consume) begin
        r_echo_buf  <= rx_data;
        r_echo_full <= 1'b1;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
`else
  logic w_unused_tx_busy;
  assign w_unused_tx_busy = tx_busy;
  assign tx_start = 1'b0;
  assign tx_data  = 8'd0;
`endif

endmodule

// File: tb/tb_matrix_input_mode.sv
// Bench for matrix_input_mode: byte-level driver, token-level reference
// model producing expected writes/allocs/events, and a monitor that pops
// and compares whenever the DUT presents an output.
`timescale 1ns/1ps
module tb_matrix_input_mode;

  localparam int EW = 8;
  localparam int AW = 10;

  localparam int E_NONE    = 0;
  localparam int E_BAD     = 1;
  localparam int E_DIM     = 2;
  localparam int E_VALUE   = 3;
  localparam int E_NOSPACE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mode_active = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          clear_rx_buffer;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic          alloc_req;
  logic [3:0]    alloc_m;
  logic [3:0]    alloc_n;
  logic          alloc_ok = 1'b0;
  logic          alloc_fail = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [EW-1:0] mem_wr_data;
  logic          commit;
  logic [3:0]    error_code;
  logic [3:0]    sub_state;

  matrix_input_mode #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_DIM(5), .ALLOC_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode_active(mode_active),
    .rx_data(rx_data), .rx_valid(rx_valid), .clear_rx_buffer(clear_rx_buffer),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .alloc_ok(alloc_ok), .alloc_fail(alloc_fail), .alloc_addr(alloc_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .commit(commit), .error_code(error_code), .sub_state(sub_state)
  );

  // scoreboard
  logic [AW+EW-1:0] exp_q[$];      // expected writes {addr, data}
  logic [4:0]       exp_ev_q[$];   // 5'h10 = commit, else {0, error code}
  logic [7:0]       exp_alloc_q[$];
  logic [7:0]       exp_tx_q[$];
  int total = 0;
  int bad = 0;
  int tx_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h required nothing", name, act);
  endtask

  // reference model: token-level interpretation of the byte stream
  int g_alloc_mode = 0;            // 0 grant, 1 fail, 2 silence
  logic [AW-1:0] g_base = '0;
  int m_ph = 0, m_acc = 0, m_pend = 0, m_m = 0, m_n = 0, m_idx = 0, m_err = 0;

  task automatic model_err(input int code);
    m_err = code;
    exp_ev_q.push_back(5'(code));
    m_ph = 0; m_acc = 0; m_pend = 0;
  endtask

  task automatic model_token(input int v);
    logic [AW-1:0] a;
    if (m_ph == 0) begin
      if (v < 1 || v > 5) model_err(E_DIM);
      else begin m_m = v; m_ph = 1; end
    end else if (m_ph == 1) begin
      if (v < 1 || v > 5) model_err(E_DIM);
      else begin
        m_n = v;
        exp_alloc_q.push_back({4'(m_m), 4'(m_n)});
        if (g_alloc_mode != 0) model_err(E_NOSPACE);
        else begin m_idx = 0; m_ph = 2; end
      end
    end else begin
      if (v > 255) model_err(E_VALUE);
      else begin
        a = g_base + AW'(m_idx);
        exp_q.push_back({a, 8'(v)});
        m_idx++;
        if (m_idx == m_m * m_n) begin
          exp_ev_q.push_back(5'h10);
          m_ph = 0;
        end
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] c);
    int tok;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (m_ph == 0 && m_pend == 0) m_err = E_NONE;
      m_acc = m_acc * 10 + int'(c - 8'h30);
      if (m_acc > 100000) m_acc = 100000;
      m_pend = 1;
    end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C) begin
      if (m_pend != 0) begin
        tok = m_acc; m_acc = 0; m_pend = 0;
        model_token(tok);
      end
    end else begin
      model_err(E_BAD);
    end
`ifdef INPUT_ECHO_EN
    exp_tx_q.push_back(c);
`endif
  endtask

  // driver tasks
  task automatic wait_alloc_done();
    int k;
    k = 0;
    while (alloc_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (alloc_req) unexpected("alloc_stuck", 32'(k));
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_alloc_done();
  endtask

  // two bytes on consecutive cycles
  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    model_byte(b0);
    model_byte(b1);
    @(negedge clk);
    rx_data = b0; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_alloc_done();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // drop mode_active and check the forced return to IDLE
  task automatic abort_and_check();
    @(negedge clk);
    mode_active = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(sub_state), 32'd0);
    check("abort_alloc_req", 32'(alloc_req), 32'd0);
    check("abort_err_held", 32'(error_code), 32'(m_err));
    m_ph = 0; m_acc = 0; m_pend = 0;
    mode_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // alloc responder
  initial begin
    forever begin
      @(negedge clk);
      alloc_ok = 1'b0;
      alloc_fail = 1'b0;
      if (alloc_req && g_alloc_mode == 0) begin
        alloc_ok = 1'b1;
        alloc_addr = g_base;
      end else if (alloc_req && g_alloc_mode == 1) begin
        alloc_fail = 1'b1;
      end
    end
  end

  // monitor
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wr_en) begin
          if (exp_q.size() == 0) unexpected("wr_unexpected", 32'({mem_wr_addr, mem_wr_data}));
          else check("wr", 32'({mem_wr_addr, mem_wr_data}), 32'(exp_q.pop_front()));
        end
        if (commit) begin
          if (exp_ev_q.size() == 0) unexpected("commit_unexpected", 32'h10);
          else check("commit_event", 32'h10, 32'(exp_ev_q.pop_front()));
        end
        if (clear_rx_buffer) begin
          if (exp_ev_q.size() == 0) unexpected("error_unexpected", 32'(error_code));
          else check("error_event", 32'(error_code), 32'(exp_ev_q.pop_front()));
        end
        if (alloc_req && !prev_req) begin
          if (exp_alloc_q.size() == 0) unexpected("alloc_unexpected", 32'({alloc_m, alloc_n}));
          else check("alloc_dims", 32'({alloc_m, alloc_n}), 32'(exp_alloc_q.pop_front()));
        end
        prev_req = alloc_req;
        if (tx_start) begin
          tx_seen++;
`ifdef INPUT_ECHO_EN
          if (exp_tx_q.size() == 0) unexpected("tx_unexpected", 32'(tx_data));
          else check("tx_echo", 32'(tx_data), 32'(exp_tx_q.pop_front()));
`endif
        end
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    string s;
    logic [7:0] delims[4];
    int mm, nn, v;
    delims[0] = 8'h20; delims[1] = 8'h0D; delims[2] = 8'h0A; delims[3] = 8'h2C;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(sub_state), 32'd0);
    check("rst_err", 32'(error_code), 32'd0);
    check("rst_outs", 32'({alloc_req, mem_wr_en, commit, clear_rx_buffer, tx_start}), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    mode_active = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_state", 32'(sub_state), 32'd0);

    // basic 2x3 at base 0x10
    g_alloc_mode = 0; g_base = 10'h10;
    send_str("2 3 1 2 3 4 5 6 ");
    // value out of range after one write
    g_base = 10'h40;
    send_str("2 2 7 256 ");
    check("err_sticky_value", 32'(error_code), 32'(E_VALUE));
    // dimension errors
    send_str("6 1 ");
    abort_and_check();
    send_str("0 3 ");
    abort_and_check();
    // bad characters
    send_str("1x ");
    check("err_sticky_bad", 32'(error_code), 32'(E_BAD));
    g_base = 10'h80;
    send_str("1 1 x");
    // no space: explicit fail, then silence
    g_alloc_mode = 1;
    send_str("1 1 ");
    check("err_sticky_nospace", 32'(error_code), 32'(E_NOSPACE));
    g_alloc_mode = 2;
    send_str("2 1 ");
    g_alloc_mode = 0;
    // abort mid-matrix, then a fresh 1x1
    g_base = 10'h100;
    send_str("2 2 1 2 ");
    abort_and_check();
    g_base = 10'h120;
    send_str("1 1 9 ");
    // byte arriving with the last write starts the next matrix
    g_base = 10'h200;
    send_str("1 1 5");
    send_pair(8'h20, 8'h33);
    g_base = 10'h210;
    send_str(" 1 4 5 6 ");

    // randomized matrices
    for (int t = 0; t < 25; t++) begin
      mm = $urandom_range(1, 5);
      nn = $urandom_range(1, 5);
      g_base = AW'($urandom_range(0, 1023));
      s = $sformatf("%0d %0d", mm, nn);
      for (int e = 0; e < mm * nn; e++) begin
        v = $urandom_range(0, 255);
        s = {s, string'(delims[$urandom_range(0, 3)])};
        if ($urandom_range(0, 4) == 0) s = {s, string'(delims[$urandom_range(0, 3)])};
        if ($urandom_range(0, 5) == 0) s = {s, "0"};
        s = {s, $sformatf("%0d", v)};
      end
      s = {s, string'(delims[$urandom_range(0, 3)])};
      send_str(s);
    end

    repeat (30) @(negedge clk);
    check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    check("event_queue_empty", 32'(exp_ev_q.size()), 32'd0);
    check("alloc_queue_empty", 32'(exp_alloc_q.size()), 32'd0);
`ifdef INPUT_ECHO_EN
    check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
`else
    check("tx_start_never", 32'(tx_seen), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
